// File: rtl/ram_sync_hs.sv
// Simple-dual-port synchronous RAM with byte-strobed writes and a
// valid/ready handshaked read path. The read pipeline is one stage (RAM
// output) or two stages (extra output register). A stalled stage keeps its
// data, so no read response is lost under backpressure. Same-cycle
// write/read collisions return either the new or the old word.
module ram_sync_hs #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter bit OUTPUT_REG = 1'b0,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic                    wvalid,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rdata_valid,
  input  logic                    rdata_ready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [DATA_WIDTH-1:0] mem_word_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic                  s1_adv_s;
  logic                  accept_s;
  logic                  s1_valid_r;
  logic [DATA_WIDTH-1:0] s1_data_r;

  // Overlay the strobed bytes of new_w onto old_w.
  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [STRB_WIDTH-1:0] strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  // Byte-strobed write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (wvalid && wstrb[i]) begin
        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign mem_word_s = mem[raddr];

  // Read word seen by S1: optionally forward same-cycle write bytes.
  always_comb begin
    rd_word_s = mem_word_s;
    if (BYPASS && wvalid && (waddr == raddr)) begin
      rd_word_s = byte_merge(mem_word_s, wdata, wstrb);
    end else begin
      rd_word_s = mem_word_s;
    end
  end

  // A request is taken only when S1 can advance; rready never looks at rvalid.
  assign rready   = s1_adv_s;
  assign accept_s = rvalid && s1_adv_s;

  // S1: capture the read snapshot on accept, hold everything while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= '0;
    end else if (s1_adv_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_data_r <= rd_word_s;
      end
    end
  end

  generate
    if (OUTPUT_REG) begin : g_out_reg
      logic                  s2_valid_r;
      logic [DATA_WIDTH-1:0] s2_data_r;
      logic                  s2_adv_s;

      assign s2_adv_s = !s2_valid_r || rdata_ready;
      assign s1_adv_s = s2_adv_s || !s1_valid_r;

      // S2: output register, loads from S1 whenever it advances.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_valid_r <= 1'b0;
          s2_data_r  <= '0;
        end else if (s2_adv_s) begin
          s2_valid_r <= s1_valid_r;
          if (s1_valid_r) begin
            s2_data_r <= s1_data_r;
          end
        end
      end

      assign rdata       = s2_data_r;
      assign rdata_valid = s2_valid_r;
    end else begin : g_no_out_reg
      assign s1_adv_s    = !s1_valid_r || rdata_ready;
      assign rdata       = s1_data_r;
      assign rdata_valid = s1_valid_r;
    end
  endgenerate

endmodule

// File: tb/tb_ram_sync_hs.sv
// Directed self-checking bench for ram_sync_hs. Two instances share all
// inputs: dut0 (single stage, write-first collision) and dut1 (output
// register, read-first collision).
module tb_ram_sync_hs;

  logic        clk;
  logic        rst;
  logic [31:0] wdata;
  logic [7:0]  waddr;
  logic        wvalid;
  logic [3:0]  wstrb;
  logic [7:0]  raddr;
  logic        rvalid;
  logic        rdata_ready;

  logic        rready0, rdata_valid0;
  logic [31:0] rdata0;
  logic        rready1, rdata_valid1;
  logic [31:0] rdata1;

  int chk_cnt;
  int pass_cnt;

  ram_sync_hs #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .OUTPUT_REG(1'b0), .BYPASS(1'b1)) dut0 (
    .clk(clk), .rst(rst), .wdata(wdata), .waddr(waddr), .wvalid(wvalid), .wstrb(wstrb),
    .raddr(raddr), .rvalid(rvalid), .rready(rready0), .rdata(rdata0),
    .rdata_valid(rdata_valid0), .rdata_ready(rdata_ready)
  );

  ram_sync_hs #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .OUTPUT_REG(1'b1), .BYPASS(1'b0)) dut1 (
    .clk(clk), .rst(rst), .wdata(wdata), .waddr(waddr), .wvalid(wvalid), .wstrb(wstrb),
    .raddr(raddr), .rvalid(rvalid), .rready(rready1), .rdata(rdata1),
    .rdata_valid(rdata_valid1), .rdata_ready(rdata_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    waddr  = a;
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
  endtask

  task automatic rd_issue(input logic [7:0] a);
    raddr  = a;
    rvalid = 1'b1;
    tick();
    rvalid = 1'b0;
  endtask

  initial begin
    int next_req;
    int next_rsp;
    logic seen;

    chk_cnt = 0;
    pass_cnt = 0;
    rst = 1'b1;
    wdata = 32'h0; waddr = 8'h0; wvalid = 1'b0; wstrb = 4'h0;
    raddr = 8'h0; rvalid = 1'b0; rdata_ready = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_valid0", {31'd0, rdata_valid0}, 32'd0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_rready0", {31'd0, rready0}, 32'd1);
    chk("rst_valid1", {31'd0, rdata_valid1}, 32'd0);
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_rready1", {31'd0, rready1}, 32'd1);

    rst = 1'b0;
    rdata_ready = 1'b1;
    tick();

    // Test 1: full write then read, latency 1 vs 2
    wr(8'h10, 32'hDEADBEEF, 4'hF);
    rd_issue(8'h10);
    chk("t1_valid0_n1", {31'd0, rdata_valid0}, 32'd1);
    chk("t1_rdata0", rdata0, 32'hDEADBEEF);
    chk("t1_valid1_n1", {31'd0, rdata_valid1}, 32'd0);
    tick();
    chk("t1_valid0_n2", {31'd0, rdata_valid0}, 32'd0);
    chk("t1_valid1_n2", {31'd0, rdata_valid1}, 32'd1);
    chk("t1_rdata1", rdata1, 32'hDEADBEEF);
    tick();

    // wstrb = 0 is a no-op
    wr(8'h10, 32'hFFFFFFFF, 4'h0);
    rd_issue(8'h10);
    chk("strb0_rdata0", rdata0, 32'hDEADBEEF);
    tick();
    tick();

    // Test 2: partial strobe merge
    wr(8'h20, 32'h11223344, 4'hF);
    wr(8'h20, 32'hAABBCCDD, 4'h5);
    rd_issue(8'h20);
    chk("t2_rdata0", rdata0, 32'h11BB33DD);
    tick();
    chk("t2_rdata1", rdata1, 32'h11BB33DD);
    tick();

    // Test 3: same-cycle collision
    wr(8'h30, 32'h0, 4'hF);
    waddr = 8'h30; wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    raddr = 8'h30; rvalid = 1'b1;
    tick();
    wvalid = 1'b0; rvalid = 1'b0;
    chk("t3_bypass1", rdata0, 32'h12345678);
    tick();
    chk("t3_bypass0_valid", {31'd0, rdata_valid1}, 32'd1);
    chk("t3_bypass0", rdata1, 32'h0);
    tick();
    rd_issue(8'h30);
    tick();
    chk("t3_after_write1", rdata1, 32'h12345678);
    tick();

    // Test 3b: partial-strobe collision on the write-first instance
    waddr = 8'h30; wdata = 32'hAAAAAAAA; wstrb = 4'h2; wvalid = 1'b1;
    raddr = 8'h30; rvalid = 1'b1;
    tick();
    wvalid = 1'b0; rvalid = 1'b0;
    chk("t3_bypass_partial", rdata0, 32'h1234AA78);
    tick();
    chk("t3_old_partial", rdata1, 32'h12345678);
    tick();

    // Test 4: back-to-back burst through two-stage pipe
    for (int i = 0; i < 8; i++) begin
      wr(i[7:0], 32'hA0000000 + i, 4'hF);
    end
    for (int c = 0; c < 12; c++) begin
      raddr  = c[7:0];
      rvalid = (c < 8);
      if (c < 8) chk($sformatf("t4_rready_%0d", c), {31'd0, rready1}, 32'd1);
      tick();
      if (c >= 1 && c <= 8) begin
        chk($sformatf("t4_valid_%0d", c), {31'd0, rdata_valid1}, 32'd1);
        chk($sformatf("t4_data_%0d", c), rdata1, 32'hA0000000 + (c - 1));
      end else begin
        chk($sformatf("t4_valid_%0d", c), {31'd0, rdata_valid1}, 32'd0);
      end
    end
    rvalid = 1'b0;
    tick();

    // Test 5: 5-cycle backpressure mid-burst, scoreboarded
    next_req = 0;
    next_rsp = 0;
    for (int c = 0; c < 30; c++) begin
      rdata_ready = !(c >= 3 && c < 8);
      rvalid = (next_req < 8);
      raddr  = next_req[7:0];
      #1;
      if (c == 5) chk("t5_rready_low", {31'd0, rready1}, 32'd0);
      if (c == 8 || c == 9) chk($sformatf("t5_nobubble_%0d", c), {31'd0, rdata_valid1}, 32'd1);
      if (rdata_valid1) begin
        chk($sformatf("t5_data_%0d", c), rdata1, 32'hA0000000 + next_rsp);
        if (rdata_ready) next_rsp++;
      end
      if (rvalid && rready1) next_req++;
      tick();
    end
    rvalid = 1'b0;
    rdata_ready = 1'b1;
    chk("t5_req_count", next_req, 32'd8);
    chk("t5_rsp_count", next_rsp, 32'd8);
    chk("t5_drained", {31'd0, rdata_valid1}, 32'd0);

    // Test 6: reset with two reads in flight
    raddr = 8'h00; rvalid = 1'b1;
    tick();
    raddr = 8'h01;
    tick();
    rvalid = 1'b0;
    chk("t6_inflight", {31'd0, rdata_valid1}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid1", {31'd0, rdata_valid1}, 32'd0);
    chk("t6_rst_valid0", {31'd0, rdata_valid0}, 32'd0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (rdata_valid0 || rdata_valid1) seen = 1'b1;
    end
    chk("t6_no_stale", {31'd0, seen}, 32'd0);
    rd_issue(8'h20);
    chk("t6_mem_kept0", rdata0, 32'h11BB33DD);
    tick();
    chk("t6_mem_kept1", rdata1, 32'h11BB33DD);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
